// File: rtl/dmem_lsu.sv
// Data-side load/store unit with word-organised backing RAM and byte-lane stores.
// Optional memory-mapped 8-bit GPIO register is enabled by defining DMEM_GPIO_EN.
module dmem_lsu #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] GPIO_ADDR   = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  gpio_out
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ALIGN  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;
    logic        we_r;
    logic [1:0]  size_r;
    logic        uns_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        err_r;
    logic [31:0] rword_r;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    logic             misalign_s;
    logic             in_range_s;
    logic             is_gpio_s;
    logic             err_s;
    logic [3:0]       lane_en_s;
    logic [31:0]      lane_data_s;
    logic             ram_we_s;
    logic             ram_re_s;
    logic [31:0]      load_data_s;
    logic [IDX_W-1:0] idx_s;

    // Shift the addressed byte/half down to bit 0 and extend it to 32 bits
    function automatic logic [31:0] align_load(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   align_load = {{24{~uns & sh[7]}}, sh[7:0]};
            2'b01:   align_load = {{16{~uns & sh[15]}}, sh[15:0]};
            default: align_load = sh;
        endcase
    endfunction

    assign idx_s      = addr_r[IDX_W+1:2];
    assign in_range_s = ({1'b0, addr_r} < RAM_BYTES);
    assign is_gpio_s  = (addr_r == GPIO_ADDR);

    // Error classification of the latched request
    always_comb begin
        misalign_s = 1'b0;
        case (size_r)
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = addr_r[0];
            2'b10:   misalign_s = (addr_r[1:0] != 2'b00);
            default: misalign_s = 1'b1;
        endcase
`ifdef DMEM_GPIO_EN
        err_s = misalign_s | ~(in_range_s | is_gpio_s);
`else
        // Without the GPIO option its address is just another unmapped location
        err_s = misalign_s | ~(in_range_s & ~is_gpio_s);
`endif
    end

    // Byte-lane enables and lane-replicated store data; no read-modify-write needed
    always_comb begin
        lane_en_s   = 4'b0000;
        lane_data_s = 32'h0000_0000;
        case (size_r)
            2'b00: begin
                lane_en_s   = 4'b0001 << addr_r[1:0];
                lane_data_s = {4{wdata_r[7:0]}};
            end
            2'b01: begin
                lane_en_s   = addr_r[1] ? 4'b1100 : 4'b0011;
                lane_data_s = {2{wdata_r[15:0]}};
            end
            2'b10: begin
                lane_en_s   = 4'b1111;
                lane_data_s = wdata_r;
            end
            default: begin
                lane_en_s   = 4'b0000;
                lane_data_s = 32'h0000_0000;
            end
        endcase
    end

    assign ram_we_s = (state_r == ACCESS) &&  we_r && !err_s && in_range_s;
    assign ram_re_s = (state_r == ACCESS) && !we_r && !err_s && in_range_s;

    // Single RAM port: byte-lane write or full-word read, contents never reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en_s[i]) begin
                    mem[idx_s][8*i +: 8] <= lane_data_s[8*i +: 8];
                end
            end
        end
        if (ram_re_s) begin
            rword_r <= mem[idx_s];
        end
    end

`ifdef DMEM_GPIO_EN
    logic [7:0] gpio_r;

    // GPIO register updates from error-free stores to its address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_r <= 8'h00;
        end else if ((state_r == ACCESS) && we_r && !err_s && is_gpio_s) begin
            gpio_r <= wdata_r[7:0];
        end else begin
            gpio_r <= gpio_r;
        end
    end

    assign gpio_out = gpio_r;
`else
    assign gpio_out = 8'h00;
`endif

    // Response data selection for the ALIGN step
    always_comb begin
        load_data_s = 32'h0000_0000;
        if (we_r || err_r) begin
            load_data_s = 32'h0000_0000;
`ifdef DMEM_GPIO_EN
        end else if (is_gpio_s) begin
            load_data_s = {24'h00_0000, gpio_r};
`endif
        end else begin
            load_data_s = align_load(rword_r, addr_r[1:0], size_r, uns_r);
        end
    end

    // Request/response sequencing: IDLE -> ACCESS -> ALIGN -> RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            we_r        <= 1'b0;
            size_r      <= 2'b00;
            uns_r       <= 1'b0;
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        we_r        <= req_we;
                        size_r      <= req_size;
                        uns_r       <= req_unsigned;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        req_ready_r <= 1'b0;
                        state_r     <= ACCESS;
                    end
                end
                ACCESS: begin
                    err_r   <= err_s;
                    state_r <= ALIGN;
                end
                ALIGN: begin
                    rsp_rdata_r <= load_data_s;
                    rsp_err_r   <= err_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rsp_err_r   <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule
